// File: rtl/eth_rx_stats_if.sv
// 512-bit AXI-Stream bundle used on both sides of the RX statistics tap.
interface eth_rx_stats_if;
  logic [511:0] tdata;
  logic [63:0]  tkeep;
  logic         tlast;
  logic         tuser;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/eth_rx_stats.sv
// Zero-latency RX stream statistics tap with saturating counters and an atomic snapshot.
//   state  | meaning
//   IDLE   | between packets, next accepted beat starts a packet
//   IN_PKT | first beat accepted, waiting for the accepted tlast beat
module eth_rx_stats #(
  parameter int COUNT_W   = 32,
  parameter int MAX_BEATS = 150,
  parameter int BEAT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  eth_rx_stats_if.slave      s_axis,
  eth_rx_stats_if.master     m_axis,
  input  logic               stats_clear,
  input  logic               snap_req,
  output logic               snap_valid,
  output logic [COUNT_W-1:0] snap_pkt_ok,
  output logic [COUNT_W-1:0] snap_pkt_err,
  output logic [COUNT_W-1:0] snap_pkt_big,
  output logic [COUNT_W-1:0] snap_bytes,
  output logic [COUNT_W-1:0] snap_stall,
  output logic [BEAT_W-1:0]  snap_max_beats,
  output logic               in_packet
);

  localparam logic [BEAT_W-1:0] MAX_LEN = BEAT_W'(MAX_BEATS);

  typedef enum logic {IDLE, IN_PKT} state_t;
  state_t state;

  logic               beat, eop;
  logic [6:0]         pop;
  logic [BEAT_W-1:0]  pkt_beats, len;
  logic [COUNT_W-1:0] pkt_ok, pkt_err, pkt_big, bytes, stall;
  logic [BEAT_W-1:0]  max_beats;
  logic [COUNT_W-1:0] ok_nxt, err_nxt, big_nxt, bytes_nxt, stall_nxt;
  logic [BEAT_W-1:0]  max_nxt;
  logic [COUNT_W-1:0] bytes_base;
  logic [BEAT_W-1:0]  max_base;
  logic [COUNT_W:0]   bytes_sum;

  assign m_axis.tdata  = s_axis.tdata;
  assign m_axis.tkeep  = s_axis.tkeep;
  assign m_axis.tlast  = s_axis.tlast;
  assign m_axis.tuser  = s_axis.tuser;
  assign m_axis.tvalid = s_axis.tvalid;
  assign s_axis.tready = m_axis.tready;

  assign beat = s_axis.tvalid & m_axis.tready;
  assign eop  = beat & s_axis.tlast;
  assign len  = (pkt_beats == '1) ? pkt_beats : pkt_beats + 1'b1;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v, input logic en);
    return (en && v != '1) ? v + 1'b1 : v;
  endfunction

  // A clear replaces the old value with zero but this cycle's event still counts.
  always_comb begin
    pop = '0;
    for (int i = 0; i < 64; i++) pop = pop + 7'(s_axis.tkeep[i]);
    ok_nxt     = sat_inc(stats_clear ? '0 : pkt_ok,  eop & ~s_axis.tuser);
    err_nxt    = sat_inc(stats_clear ? '0 : pkt_err, eop &  s_axis.tuser);
    big_nxt    = sat_inc(stats_clear ? '0 : pkt_big, eop & (len > MAX_LEN));
    stall_nxt  = sat_inc(stats_clear ? '0 : stall,   s_axis.tvalid & ~m_axis.tready);
    bytes_base = stats_clear ? '0 : bytes;
    bytes_sum  = {1'b0, bytes_base} + (beat ? {{(COUNT_W-6){1'b0}}, pop} : '0);
    bytes_nxt  = bytes_sum[COUNT_W] ? '1 : bytes_sum[COUNT_W-1:0];
    max_base   = stats_clear ? '0 : max_beats;
    max_nxt    = (eop && len > max_base) ? len : max_base;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_ok         <= '0;
      pkt_err        <= '0;
      pkt_big        <= '0;
      bytes          <= '0;
      stall          <= '0;
      max_beats      <= '0;
      snap_valid     <= 1'b0;
      snap_pkt_ok    <= '0;
      snap_pkt_err   <= '0;
      snap_pkt_big   <= '0;
      snap_bytes     <= '0;
      snap_stall     <= '0;
      snap_max_beats <= '0;
    end else begin
      pkt_ok     <= ok_nxt;
      pkt_err    <= err_nxt;
      pkt_big    <= big_nxt;
      bytes      <= bytes_nxt;
      stall      <= stall_nxt;
      max_beats  <= max_nxt;
      snap_valid <= snap_req;
      if (snap_req) begin
        snap_pkt_ok    <= ok_nxt;
        snap_pkt_err   <= err_nxt;
        snap_pkt_big   <= big_nxt;
        snap_bytes     <= bytes_nxt;
        snap_stall     <= stall_nxt;
        snap_max_beats <= max_nxt;
      end
    end
  end

  // Packet tracking is deliberately untouched by stats_clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_packet <= 1'b0;
      pkt_beats <= '0;
    end else begin
      case (state)
        IDLE: if (beat && !s_axis.tlast) begin
          state     <= IN_PKT;
          in_packet <= 1'b1;
        end
        IN_PKT: if (eop) begin
          state     <= IDLE;
          in_packet <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          in_packet <= 1'b0;
        end
      endcase
      if (eop)
        pkt_beats <= '0;
      else if (beat && pkt_beats != '1)
        pkt_beats <= pkt_beats + 1'b1;
    end
  end

endmodule

// File: tb/tb_eth_rx_stats.sv
// Random and directed stimulus for two eth_rx_stats instances (32-bit/MAX 4 and 8-bit/MAX 150).
module tb_eth_rx_stats;
  localparam int CW_A = 32, MB_A = 4;
  localparam int CW_B = 8,  MB_B = 150;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [511:0] tdata;
  logic [63:0]  tkeep;
  logic tlast, tuser, tvalid, rdy, clr, snap;

  eth_rx_stats_if s_a(), m_a(), s_b(), m_b();
  assign s_a.tdata = tdata;  assign s_b.tdata = tdata;
  assign s_a.tkeep = tkeep;  assign s_b.tkeep = tkeep;
  assign s_a.tlast = tlast;  assign s_b.tlast = tlast;
  assign s_a.tuser = tuser;  assign s_b.tuser = tuser;
  assign s_a.tvalid = tvalid; assign s_b.tvalid = tvalid;
  assign m_a.tready = rdy;   assign m_b.tready = rdy;

  logic            sv_a, inp_a, sv_b, inp_b;
  logic [CW_A-1:0] ok_a, err_a, big_a, byt_a, stl_a;
  logic [CW_B-1:0] ok_b, err_b, big_b, byt_b, stl_b;
  logic [15:0]     mx_a, mx_b;

  eth_rx_stats #(.COUNT_W(CW_A), .MAX_BEATS(MB_A), .BEAT_W(16)) dut_a (
    .clk(clk), .rst(rst), .s_axis(s_a), .m_axis(m_a), .stats_clear(clr), .snap_req(snap),
    .snap_valid(sv_a), .snap_pkt_ok(ok_a), .snap_pkt_err(err_a), .snap_pkt_big(big_a),
    .snap_bytes(byt_a), .snap_stall(stl_a), .snap_max_beats(mx_a), .in_packet(inp_a));

  eth_rx_stats #(.COUNT_W(CW_B), .MAX_BEATS(MB_B), .BEAT_W(16)) dut_b (
    .clk(clk), .rst(rst), .s_axis(s_b), .m_axis(m_b), .stats_clear(clr), .snap_req(snap),
    .snap_valid(sv_b), .snap_pkt_ok(ok_b), .snap_pkt_err(err_b), .snap_pkt_big(big_b),
    .snap_bytes(byt_b), .snap_stall(stl_b), .snap_max_beats(mx_b), .in_packet(inp_b));

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: unbounded event counts since last clear; saturation is min() against the width limit.
  longint c_ok, c_err, c_big_a, c_big_b, c_bytes, c_stall, c_max;
  longint e_ok, e_err, e_big_a, e_big_b, e_bytes, e_stall, e_max;
  int     cur_len;
  bit     m_inpkt, e_sv;

  function automatic longint sat(input longint v, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    c_ok = 0; c_err = 0; c_big_a = 0; c_big_b = 0; c_bytes = 0; c_stall = 0; c_max = 0;
    e_ok = 0; e_err = 0; e_big_a = 0; e_big_b = 0; e_bytes = 0; e_stall = 0; e_max = 0;
    cur_len = 0; m_inpkt = 0; e_sv = 0;
  endtask

  task automatic model_step();
    bit beat, eop;
    longint len;
    beat = tvalid & rdy;
    eop  = beat & tlast;
    if (clr) begin
      c_ok = 0; c_err = 0; c_big_a = 0; c_big_b = 0; c_bytes = 0; c_stall = 0; c_max = 0;
    end
    if (eop) begin
      len = sat(cur_len + 1, 16);
      if (tuser) c_err++; else c_ok++;
      if (len > MB_A) c_big_a++;
      if (len > MB_B) c_big_b++;
      if (len > c_max) c_max = len;
      cur_len = 0;
    end else if (beat) begin
      cur_len = int'(sat(cur_len + 1, 16));
    end
    if (beat) c_bytes += $countones(tkeep);
    if (tvalid && !rdy) c_stall++;
    if (beat) m_inpkt = !tlast;
    e_sv = snap;
    if (snap) begin
      e_ok = c_ok; e_err = c_err; e_big_a = c_big_a; e_big_b = c_big_b;
      e_bytes = c_bytes; e_stall = c_stall; e_max = c_max;
    end
  endtask

  task automatic check_outputs();
    check("in_packet_a", longint'(inp_a), longint'(m_inpkt));
    check("in_packet_b", longint'(inp_b), longint'(m_inpkt));
    check("snap_valid_a", longint'(sv_a), longint'(e_sv));
    check("snap_valid_b", longint'(sv_b), longint'(e_sv));
    check("snap_ok_a",   longint'(ok_a),  sat(e_ok, CW_A));
    check("snap_err_a",  longint'(err_a), sat(e_err, CW_A));
    check("snap_big_a",  longint'(big_a), sat(e_big_a, CW_A));
    check("snap_bytes_a", longint'(byt_a), sat(e_bytes, CW_A));
    check("snap_stall_a", longint'(stl_a), sat(e_stall, CW_A));
    check("snap_max_a",  longint'(mx_a),  e_max);
    check("snap_ok_b",   longint'(ok_b),  sat(e_ok, CW_B));
    check("snap_err_b",  longint'(err_b), sat(e_err, CW_B));
    check("snap_big_b",  longint'(big_b), sat(e_big_b, CW_B));
    check("snap_bytes_b", longint'(byt_b), sat(e_bytes, CW_B));
    check("snap_stall_b", longint'(stl_b), sat(e_stall, CW_B));
    check("snap_max_b",  longint'(mx_b),  e_max);
  endtask

  // Called at a negedge: drive, check the pass-through, clock once, check registered state.
  task automatic cycle(input bit v, input bit r, input bit l, input bit u,
                       input logic [63:0] k, input bit c, input bit s);
    tvalid = v; rdy = r; tlast = l; tuser = u; tkeep = k; clr = c; snap = s;
    for (int i = 0; i < 16; i++) tdata[i*32 +: 32] = $urandom;
    #1;
    check("pt_data_lo", longint'(m_a.tdata[63:0]), longint'(tdata[63:0]));
    check("pt_data_hi", longint'(m_b.tdata[511:448]), longint'(tdata[511:448]));
    check("pt_keep", longint'(m_a.tkeep), longint'(k));
    check("pt_ctl", longint'({m_b.tvalid, m_b.tlast, m_b.tuser}), longint'({v, l, u}));
    check("pt_tready", longint'({s_a.tready, s_b.tready}), longint'({r, r}));
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input bit c, input bit s);
    cycle(0, 1, 0, 0, 64'h0, c, s);
  endtask

  task automatic packet(input int n, input bit u);
    for (int i = 0; i < n; i++) cycle(1, 1, i == n - 1, u, '1, 0, 0);
  endtask

  initial begin
    tvalid = 0; rdy = 1; tlast = 0; tuser = 0; tkeep = '0; clr = 0; snap = 0; tdata = '0;
    rst = 1;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 0;

    // single full beat
    cycle(1, 1, 1, 0, '1, 0, 0);
    idle(0, 1);
    check("s1_valid", longint'(sv_a), 1);
    check("s1_ok", longint'(ok_a), 1);
    check("s1_bytes", longint'(byt_a), 64);
    check("s1_max", longint'(mx_a), 1);
    idle(0, 0);
    check("s1_valid_drop", longint'(sv_a), 0);

    // 3-beat error packet with partial last beat
    idle(1, 0);
    cycle(1, 1, 0, 0, '1, 0, 0);
    check("s2_inpkt1", longint'(inp_a), 1);
    cycle(1, 1, 0, 0, '1, 0, 0);
    check("s2_inpkt2", longint'(inp_a), 1);
    cycle(1, 1, 1, 1, 64'hFF, 0, 0);
    check("s2_inpkt3", longint'(inp_a), 0);
    idle(0, 1);
    check("s2_err", longint'(err_a), 1);
    check("s2_ok", longint'(ok_a), 0);
    check("s2_bytes", longint'(byt_a), 136);
    check("s2_max", longint'(mx_a), 3);

    // oversize boundary on dut_a
    idle(1, 0);
    packet(5, 0);
    idle(0, 1);
    check("s3_big5", longint'(big_a), 1);
    check("s3_max5", longint'(mx_a), 5);
    packet(4, 0);
    idle(0, 1);
    check("s3_big4", longint'(big_a), 1);
    check("s3_big_b", longint'(big_b), 0);

    // stalls
    idle(1, 0);
    repeat (7) cycle(1, 0, 0, 0, '1, 0, 0);
    idle(0, 1);
    check("s4_stall", longint'(stl_a), 7);
    check("s4_bytes", longint'(byt_a), 0);

    // clear coincident with eop and snap
    idle(1, 0);
    repeat (10) cycle(1, 1, 1, 0, '1, 0, 0);
    idle(0, 1);
    check("s5_ok10", longint'(ok_a), 10);
    cycle(1, 1, 1, 0, '1, 1, 1);
    check("s5_ok_clr", longint'(ok_a), 1);

    // byte saturation on 8-bit instance, then async reset mid-packet
    idle(1, 0);
    packet(5, 0);
    idle(0, 1);
    check("s6_bytes_b", longint'(byt_b), 255);
    check("s6_bytes_a", longint'(byt_a), 320);
    cycle(1, 1, 0, 0, '1, 0, 0);
    cycle(1, 1, 0, 0, '1, 0, 0);
    check("s6_inpkt", longint'(inp_a), 1);
    tvalid = 0;
    #2 rst = 1;
    #1;
    check("s6_rst_inpkt_a", longint'(inp_a), 0);
    check("s6_rst_inpkt_b", longint'(inp_b), 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    cycle(1, 1, 1, 0, '1, 0, 0);
    idle(0, 1);
    check("s6_after_rst_max", longint'(mx_a), 1);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) == 0, {$urandom, $urandom},
            $urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
